ram_1port_master: RTL and testbench
===================================

RAM_1PORT_MASTER -- requirements
Module: ram_1port_master

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on posedge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-003 SHALL have port cmd_valid, input, 1 bit: command offered.
REQ-004 SHALL have port cmd_ready, output, 1 bit: command accepted this cycle when cmd_valid is also 1.
REQ-005 SHALL have port cmd_wr, input, 1 bit: 1 = write (fill) burst, 0 = read burst.
REQ-006 SHALL have port cmd_addr, input, 7 bits: start address.
REQ-007 SHALL have port cmd_len, input, 3 bits: beats minus 1, giving 1..8 beats.
REQ-008 SHALL have port cmd_wdata, input, 4 bits: fill value written on every beat of a write burst.
REQ-009 SHALL have port ram_enb, output, 1 bit: to the RAM, 1 = write, 0 = read.
REQ-010 SHALL have port ram_addr, output, 7 bits: RAM address.
REQ-011 SHALL have port ram_wdata, output, 4 bits: RAM write data.
REQ-012 SHALL have port ram_rdata, input, 4 bits: RAM read data, updated by the RAM on negedge clk while ram_enb = 0.
REQ-013 SHALL have port rsp_valid, output, 1 bit: read beat available.
REQ-014 SHALL have port rsp_ready, input, 1 bit: consumer takes the beat.
REQ-015 SHALL have port rsp_data, output, 4 bits: read beat data.
REQ-016 SHALL have port rsp_last, output, 1 bit: final beat of the burst.
REQ-017 SHALL have port busy, output, 1 bit: 1 when state is not IDLE or any response is pending.

Function
REQ-018 SHALL implement FSM states IDLE, WR and RD; cmd_ready = 1 only in IDLE (and not in reset).
REQ-019 SHALL, on a command handshake, latch addr, len, wr and wdata, and move to WR if cmd_wr = 1, else to RD.
REQ-020 SHALL drive ram_enb, ram_addr and ram_wdata from registers only; there are no combinational paths from inputs to the RAM ports.
REQ-021 SHALL, in WR, issue one beat per cycle with ram_enb = 1, ram_addr = current address and ram_wdata = the latched value; beat k is driven in cycle A+1+k, where A is the acceptance cycle.
REQ-022 SHALL, in RD, issue a beat by driving ram_enb = 0 and ram_addr = current address, then sample ram_rdata at the next posedge and push {data, last} into the response buffer; the beat's rsp_valid rises one cycle after its issue cycle.
REQ-023 SHALL issue a read beat only if (buffer occupancy + beats in flight) is less than the buffer depth, counting a same-cycle pop as freeing a slot.
REQ-024 SHALL increment the current address by 1 modulo 128 after each beat, so 127 wraps to 0.
REQ-025 SHALL return to IDLE in the cycle after the last beat issues, and hold ram_enb = 0 whenever it is not in WR.
REQ-026 SHALL allow a new command to be accepted in IDLE while responses are still pending; those responses stay in order.
REQ-027 SHALL hold rsp_data and rsp_last stable while rsp_valid = 1 and rsp_ready = 0.
REQ-028 SHALL assert rsp_last only on beat cmd_len of a read burst.

Reset
REQ-029 SHALL, when rst = 1 at a posedge, force state IDLE, cmd_ready = 0, ram_enb = 0, ram_addr = 0, ram_wdata = 0, rsp_valid = 0, rsp_data = 0, rsp_last = 0 and busy = 0, and empty the buffer.
REQ-030 SHALL abort any burst in progress at reset: remaining beats are dropped and in-flight read data is discarded.
REQ-031 SHALL assert cmd_ready in the first cycle after rst deasserts.

Configuration
REQ-032 SHALL use the macro RAM1P_MST_RSP_FIFO_EN to select the response buffer depth.
REQ-033 SHALL, when RAM1P_MST_RSP_FIFO_EN is defined, use a 2-entry response FIFO, giving one read beat per cycle when rsp_ready stays at 1.
REQ-034 SHALL, when RAM1P_MST_RSP_FIFO_EN is undefined, use a single response register, giving at most one read beat per 2 cycles.

Verification
REQ-035 SHALL cover write: cmd wr = 1, addr = 5, len = 3, wdata = 0xA -> ram_enb = 1 for 4 cycles, ram_addr = 5, 6, 7, 8, ram_wdata = 0xA, then ram_enb = 0.
REQ-036 SHALL cover read: after REQ-035, cmd wr = 0, addr = 5, len = 3, with rsp_ready = 1 -> 4 beats of 0xA, rsp_last on the 4th only; first rsp_valid 2 cycles after acceptance.
REQ-037 SHALL cover wrap: a fill at addr = 126, len = 2 -> writes to 126, 127, 0; a read-back of addr = 0 returns the fill value.
REQ-038 SHALL cover back-pressure: a read with len = 7 and rsp_ready = 0 for 10 cycles -> no beat is lost or duplicated and rsp_data is stable while stalled; with the macro, the beat sequence is unchanged.
REQ-039 SHALL cover reset mid-burst: rst = 1 during beat 2 of an 8-beat read -> the next cycle has rsp_valid = 0, busy = 0 and ram_enb = 0, and cmd_ready = 1 after release.
REQ-040 SHALL cover the throughput check: an 8-beat read with rsp_ready = 1 completes in 9 response cycles with the macro and 16 without it.

Source files
------------

// File: rtl/ram_1port_master.sv
// Purpose: burst master for a single-port RAM; fill (write) and read bursts of 1..8 beats.
// Latency: first RAM beat is driven the cycle after command accept; read data appears the cycle after its issue.
// Backpressure: cmd_ready only in IDLE; read issue stalls while the response buffer (1 or 2 deep) is committed.
//
// Optional feature macro: RAM1P_MST_RSP_FIFO_EN
//   defined   -> 2-entry response FIFO, one read beat per cycle with rsp_ready held high
//   undefined -> single response register, at most one read beat every 2 cycles
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   cmd_valid/cmd_ready          command handshake
//   cmd_wr, cmd_addr, cmd_len,   burst type, start address, beats-1, fill value
//   cmd_wdata
//   ram_enb, ram_addr, ram_wdata registered RAM controls (ram_enb=1 write, 0 read)
//   ram_rdata                    RAM read data, valid at the posedge after a read address
//   rsp_valid/rsp_ready,         read response stream with end-of-burst marker
//   rsp_data, rsp_last
//   busy                         burst active or responses outstanding

module ram_1port_master (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_wr,
    input  logic [6:0] cmd_addr,
    input  logic [2:0] cmd_len,
    input  logic [3:0] cmd_wdata,
    output logic       ram_enb,
    output logic [6:0] ram_addr,
    output logic [3:0] ram_wdata,
    input  logic [3:0] ram_rdata,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [3:0] rsp_data,
    output logic       rsp_last,
    output logic       busy
);

`ifdef RAM1P_MST_RSP_FIFO_EN
    localparam logic [2:0] RSP_DEPTH = 3'd2;
`else
    localparam logic [2:0] RSP_DEPTH = 3'd1;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2
    } state_t;

    state_t     state_q;
    logic       ram_enb_q;
    logic [6:0] ram_addr_q;
    logic [3:0] ram_wdata_q;
    logic [2:0] len_q;
    logic [2:0] cnt_q;      // index of the beat currently on the RAM port
    logic       issue_q;    // a read beat is on the RAM port this cycle

    // Response buffer: head is what the consumer sees, tail only used when 2 deep.
    logic [1:0] occ_q;
    logic [3:0] head_data_q;
    logic       head_last_q;
    logic [3:0] tail_data_q;
    logic       tail_last_q;

    logic       pop;
    logic       push;
    logic       push_last;
    logic [2:0] slots_used;
    logic       can_issue;

    assign cmd_ready = (state_q == IDLE) && !rst;
    assign ram_enb   = ram_enb_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign rsp_valid = (occ_q != 2'd0);
    assign rsp_data  = head_data_q;
    assign rsp_last  = head_last_q;
    assign busy      = (state_q != IDLE) || (occ_q != 2'd0) || issue_q;

    assign pop       = rsp_valid && rsp_ready;
    assign push      = issue_q;
    assign push_last = (cnt_q == len_q);

    // Slots committed after this edge: stored beats plus the one being read now,
    // less the one leaving this cycle. The next beat may issue only into a free slot.
    assign slots_used = {1'b0, occ_q} + {2'b00, issue_q} - {2'b00, pop};
    assign can_issue  = (slots_used < RSP_DEPTH);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ram_enb_q   <= 1'b0;
            ram_addr_q  <= 7'd0;
            ram_wdata_q <= 4'd0;
            len_q       <= 3'd0;
            cnt_q       <= 3'd0;
            issue_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        len_q       <= cmd_len;
                        cnt_q       <= 3'd0;
                        ram_addr_q  <= cmd_addr;
                        ram_wdata_q <= cmd_wdata;
                        if (cmd_wr) begin
                            state_q   <= WR;
                            ram_enb_q <= 1'b1;
                        end else begin
                            state_q <= RD;
                            issue_q <= can_issue;
                        end
                    end
                end
                WR: begin
                    ram_addr_q <= ram_addr_q + 7'd1;
                    if (cnt_q == len_q) begin
                        state_q   <= IDLE;
                        ram_enb_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 3'd1;
                    end
                end
                RD: begin
                    if (issue_q) begin
                        ram_addr_q <= ram_addr_q + 7'd1;
                        if (cnt_q == len_q) begin
                            state_q <= IDLE;
                            issue_q <= 1'b0;
                        end else begin
                            cnt_q   <= cnt_q + 3'd1;
                            issue_q <= can_issue;
                        end
                    end else begin
                        issue_q <= can_issue;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    ram_enb_q <= 1'b0;
                    issue_q   <= 1'b0;
                end
            endcase
        end
    end

    // Head only changes on a pop or a push into an empty buffer, so the
    // presented beat stays stable while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q       <= 2'd0;
            head_data_q <= 4'd0;
            head_last_q <= 1'b0;
            tail_data_q <= 4'd0;
            tail_last_q <= 1'b0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (occ_q == 2'd0) begin
                        head_data_q <= ram_rdata;
                        head_last_q <= push_last;
                    end else begin
                        tail_data_q <= ram_rdata;
                        tail_last_q <= push_last;
                    end
                    occ_q <= occ_q + 2'd1;
                end
                2'b01: begin
                    if (occ_q == 2'd2) begin
                        head_data_q <= tail_data_q;
                        head_last_q <= tail_last_q;
                    end
                    occ_q <= occ_q - 2'd1;
                end
                2'b11: begin
                    if (occ_q == 2'd2) begin
                        head_data_q <= tail_data_q;
                        head_last_q <= tail_last_q;
                        tail_data_q <= ram_rdata;
                        tail_last_q <= push_last;
                    end else begin
                        head_data_q <= ram_rdata;
                        head_last_q <= push_last;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_1port_master.sv
module tb_ram_1port_master;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_wr;
    logic [6:0] cmd_addr;
    logic [2:0] cmd_len;
    logic [3:0] cmd_wdata;
    logic       ram_enb;
    logic [6:0] ram_addr;
    logic [3:0] ram_wdata;
    logic [3:0] ram_rdata = 4'd0;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [3:0] rsp_data;
    logic       rsp_last;
    logic       busy;

    int n_chk  = 0;
    int n_fail = 0;

`ifdef RAM1P_MST_RSP_FIFO_EN
    localparam int THRU_CYC = 9;
    localparam int RST_CYC  = 3;
`else
    localparam int THRU_CYC = 16;
    localparam int RST_CYC  = 5;
`endif

    ram_1port_master dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_wr    (cmd_wr),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .cmd_wdata (cmd_wdata),
        .ram_enb   (ram_enb),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_last  (rsp_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // RAM model: unwritten locations read back as (addr[3:0] ^ 5).
    bit [3:0] mem [128];
    bit       written [128];

    always @(posedge clk) begin
        if (ram_enb) begin
            mem[ram_addr]     <= ram_wdata;
            written[ram_addr] <= 1'b1;
        end
    end

    always @(negedge clk) begin
        if (!ram_enb)
            ram_rdata <= written[ram_addr] ? mem[ram_addr] : (ram_addr[3:0] ^ 4'h5);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_cmd_ready(input string name);
        int n = 0;
        while (!cmd_ready && n < 50) begin
            tick();
            n++;
        end
        chk({name, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    endtask

    task automatic run_write(input logic [6:0] addr, input logic [2:0] len,
                             input logic [3:0] wdata, input string name);
        logic [6:0] ea;
        wait_cmd_ready(name);
        cmd_valid = 1'b1;
        cmd_wr    = 1'b1;
        cmd_addr  = addr;
        cmd_len   = len;
        cmd_wdata = wdata;
        tick();
        cmd_valid = 1'b0;
        for (int k = 0; k <= int'(len); k++) begin
            ea = addr + 7'(k);
            chk($sformatf("%s_enb%0d", name, k), 32'(ram_enb), 32'd1);
            chk($sformatf("%s_addr%0d", name, k), 32'(ram_addr), 32'(ea));
            chk($sformatf("%s_wdata%0d", name, k), 32'(ram_wdata), 32'(wdata));
            tick();
        end
        chk({name, "_enb_off"}, 32'(ram_enb), 32'd0);
    endtask

    // Reads a burst; exp holds beat k in bits [4k+3:4k]. rsp_ready is low for
    // cycles 1..stall after acceptance. exp_first/exp_done <= 0 skip timing checks.
    task automatic run_read(input logic [6:0] addr, input logic [2:0] len,
                            input logic [31:0] exp, input int stall,
                            input int exp_first, input int exp_done, input string name);
        int         got = 0;
        int         first_cyc = -1;
        int         done_cyc = -1;
        bit         held_vld = 0;
        logic [3:0] held_data = 4'd0;
        logic       held_last = 1'b0;
        bit         enb_seen = 0;
        logic [31:0] expv;
        expv = exp;
        wait_cmd_ready(name);
        cmd_valid = 1'b1;
        cmd_wr    = 1'b0;
        cmd_addr  = addr;
        cmd_len   = len;
        cmd_wdata = 4'h0;
        rsp_ready = 1'b0;
        tick();
        cmd_valid = 1'b0;
        for (int cyc = 1; cyc < 200 && got <= int'(len); cyc++) begin
            rsp_ready = (cyc > stall);
            if (ram_enb) enb_seen = 1;
            if (rsp_valid) begin
                if (first_cyc < 0) first_cyc = cyc;
                if (held_vld) begin
                    chk($sformatf("%s_hold_data_c%0d", name, cyc), 32'(rsp_data), 32'(held_data));
                    chk($sformatf("%s_hold_last_c%0d", name, cyc), 32'(rsp_last), 32'(held_last));
                end
                if (rsp_ready) begin
                    chk($sformatf("%s_data%0d", name, got), 32'(rsp_data), 32'(expv[4*got +: 4]));
                    chk($sformatf("%s_last%0d", name, got), 32'(rsp_last), 32'(got == int'(len)));
                    got++;
                    if (got == int'(len) + 1) done_cyc = cyc;
                    held_vld = 0;
                end else begin
                    held_vld  = 1;
                    held_data = rsp_data;
                    held_last = rsp_last;
                end
            end
            tick();
        end
        rsp_ready = 1'b0;
        chk({name, "_beats"}, 32'(got), 32'(int'(len) + 1));
        chk({name, "_enb_low"}, 32'(enb_seen), 32'd0);
        chk({name, "_busy_end"}, 32'(busy), 32'd0);
        chk({name, "_no_extra"}, 32'(rsp_valid), 32'd0);
        if (exp_first > 0) chk({name, "_first_cyc"}, 32'(first_cyc), 32'(exp_first));
        if (exp_done > 0) chk({name, "_done_cyc"}, 32'(done_cyc), 32'(exp_done));
    endtask

    typedef struct {
        logic        wr;
        logic [6:0]  addr;
        logic [2:0]  len;
        logic [3:0]  wdata;
        logic [31:0] exp;
        int          done;
    } vec_t;

    vec_t vecs [7];

    initial begin
        vecs[0] = '{1'b1, 7'd5,    3'd3, 4'hA, 32'h0,        0};
        vecs[1] = '{1'b0, 7'd5,    3'd3, 4'h0, 32'h0000AAAA, 0};
        vecs[2] = '{1'b1, 7'd126,  3'd2, 4'h3, 32'h0,        0};
        vecs[3] = '{1'b0, 7'd0,    3'd0, 4'h0, 32'h00000003, 0};
        vecs[4] = '{1'b0, 7'd126,  3'd2, 4'h0, 32'h00000333, 0};
        vecs[5] = '{1'b0, 7'd8,    3'd1, 4'h0, 32'h000000CA, 0};
        vecs[6] = '{1'b0, 7'h20,   3'd7, 4'h0, 32'h23016745, THRU_CYC};

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_wr    = 1'b0;
        cmd_addr  = 7'd0;
        cmd_len   = 3'd0;
        cmd_wdata = 4'd0;
        rsp_ready = 1'b0;
        repeat (3) tick();
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_ram_enb",   32'(ram_enb),   32'd0);
        chk("rst_ram_addr",  32'(ram_addr),  32'd0);
        chk("rst_ram_wdata", 32'(ram_wdata), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data",  32'(rsp_data),  32'd0);
        chk("rst_rsp_last",  32'(rsp_last),  32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        rst = 1'b0;
        #1;
        chk("rst_release_cmd_ready", 32'(cmd_ready), 32'd1);

        for (int i = 0; i < 7; i++) begin
            if (vecs[i].wr)
                run_write(vecs[i].addr, vecs[i].len, vecs[i].wdata, $sformatf("v%0d_wr", i));
            else
                run_read(vecs[i].addr, vecs[i].len, vecs[i].exp, 0, 2, vecs[i].done,
                         $sformatf("v%0d_rd", i));
        end

        // Consumer stalled for 10 cycles on an 8-beat read.
        run_read(7'h20, 3'd7, 32'h23016745, 10, -1, -1, "bp_rd");

        // Reset while beat 2 of an 8-beat read is on the RAM port.
        wait_cmd_ready("mid_rst");
        cmd_valid = 1'b1;
        cmd_wr    = 1'b0;
        cmd_addr  = 7'h20;
        cmd_len   = 3'd7;
        rsp_ready = 1'b1;
        tick();
        cmd_valid = 1'b0;
        repeat (RST_CYC - 1) tick();
        chk("mid_rst_beat2_addr", 32'(ram_addr), 32'h22);
        rst = 1'b1;
        tick();
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_busy",      32'(busy),      32'd0);
        chk("mid_rst_ram_enb",   32'(ram_enb),   32'd0);
        chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("mid_rst_ram_addr",  32'(ram_addr),  32'd0);
        rst = 1'b0;
        #1;
        chk("mid_rst_release_cmd_ready", 32'(cmd_ready), 32'd1);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("mid_rst_drop%0d", k), 32'(rsp_valid), 32'd0);
        end
        rsp_ready = 1'b0;

        // Wrapped data still readable after the abort.
        run_read(7'd127, 3'd1, 32'h00000033, 0, 2, -1, "post_rst_rd");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
